write_resp_channel_arbiter: RTL
===============================

# write_resp_channel_arbiter

Round-robin arbiter and response buffer for the interconnect's write-response (B) path. It takes B responses from two slave-side ports, grants one at a time, and registers its ID and BRESP. It then drives the selection inputs (Sel_Resp_ID, Sel_Valid, Sel_Write_Resp) of Write_Resp_Channel_Dec, which routes the response to the addressed master. The block owns the slave-side bready handshake and retires each response only when the target master accepts it.

## Interface
- Num_Of_Slaves, 2: slave-side B ports; fixed at 2 in this revision.
- Num_Of_Masters, 2: master-side B ports; must equal 2^Master_ID_Width.
- Master_ID_Width, 1: width of BID; value selects the destination master.

Ports:
- ACLK  in  1  clock; all state on rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- M00_AXI_bvalid, M01_AXI_bvalid  in  1  response valid from slave 0 / 1.
- M00_AXI_bresp, M01_AXI_bresp  in  2  BRESP from slave 0 / 1.
- M00_AXI_bid, M01_AXI_bid  in  Master_ID_Width  destination master ID from slave 0 / 1.
- M00_AXI_bready, M01_AXI_bready  out  1  accept pulse to slave 0 / 1.
- S00_AXI_bready, S01_AXI_bready  in  1  ready from master 0 / 1.
- Sel_Resp_ID  out  Master_ID_Width  registered destination ID to the decoder.
- Sel_Valid  out  1  registered valid to the decoder.
- Sel_Write_Resp  out  2  registered BRESP to the decoder.
- Err_Count  out  16  SLVERR/DECERR count; present only under WRITE_RESP_ARB_ERR_COUNT_EN.

## Operation
- States: IDLE (buffer empty) and BUSY (buffer holds one response, Sel_Valid=1).
- Grant is computed combinationally among asserted bvalids.
  - Round-robin: the slave after last_grant has priority.
  - last_grant resets to slave 1, so slave 0 wins the first tie.
- Capture occurs when state==IDLE and any bvalid is asserted, or when state==BUSY with a retire and any bvalid is asserted:
  - Mxx_AXI_bready=1 for the granted slave only, combinationally, in that cycle.
  - On the next edge: Sel_Resp_ID<=bid, Sel_Write_Resp<=bresp, last_grant<=granted slave, state<=BUSY.
- Retire: state==BUSY and the S0x_AXI_bready selected by Sel_Resp_ID is 1.
  - With no capture in the same cycle: next state IDLE, Sel_Valid<=0.
  - With a capture in the same cycle: stay BUSY (back-to-back).
- Mxx_AXI_bready is never asserted in BUSY without a retire in the same cycle.
- Sel_* outputs are stable while BUSY and not retiring.
- Ready from a non-selected master is ignored.
- Slave bvalid dropping without a handshake is tolerated: nothing is captured.

## Timing
- Reset values: Sel_Valid=0, Sel_Resp_ID=0, Sel_Write_Resp=2'b00, state=IDLE, last_grant=1, Err_Count=0. Both Mxx_AXI_bready are 0 while ARESET is high.
- Latency: slave handshake at cycle N gives Sel_Valid=1 at cycle N+1.
- Throughput: one response per cycle while master ready stays high.
- Combinational path S0x_AXI_bready → Mxx_AXI_bready exists by design. Master-side ready must not depend on slave-side bready.
- Simultaneous bvalid: exactly one grant per cycle. The loser keeps bvalid high and wins next, so a slave waits at most 1 grant.
- Reset mid-operation: a buffered response is discarded and outputs return to reset values immediately (asynchronous).

## Configuration
- WRITE_RESP_ARB_ERR_COUNT_EN defined:
  - Err_Count increments on every retire whose Sel_Write_Resp[1]==1 (SLVERR or DECERR).
  - Saturates at 16'hFFFF.
- Undefined: the Err_Count port and its counter are absent. All other behaviour is identical.

## Structure
- Package write_resp_arb_pkg:
  - state enum (ST_IDLE, ST_BUSY).
  - BRESP constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - ERR_CNT_W=16.
- Sub-module rr_arbiter_2: request[1:0] and last_grant in, one-hot grant[1:0] out. Purely combinational.

## Test plan
- Reset: assert ARESET mid-BUSY → Sel_Valid=0, both Mxx_AXI_bready=0 immediately; after release, state IDLE.
- Single response: M00 bvalid=1, bid=1, bresp=2'b01 → M00_AXI_bready pulse 1 cycle; next cycle Sel_Valid=1, Sel_Resp_ID=1, Sel_Write_Resp=2'b01; held until S01_AXI_bready=1, then Sel_Valid=0.
- Wrong-master ready: buffered response has Sel_Resp_ID=0, S01_AXI_bready=1, S00_AXI_bready=0 for 5 cycles → Sel_Valid stays 1, no new capture.
- Contention: both bvalid=1 from reset, both masters ready → grants alternate slave 0, 1, 0, 1; Sel_Valid continuous; four responses in four consecutive cycles.
- Back-to-back: retire and new M01 bvalid in the same cycle → M01_AXI_bready=1 that cycle; Sel_Valid never drops.
- Error count (macro on): retire bresp 2'b10, 2'b11, 2'b00 → Err_Count=2. Preload 16'hFFFF, then one further SLVERR retire → Err_Count stays 16'hFFFF.

Source files
------------

// File: rtl/write_resp_channel_arbiter_pkg.sv
// Shared types and constants for the write-response channel arbiter.
// Optional error counter is enabled by defining WRITE_RESP_ARB_ERR_COUNT_EN.
package write_resp_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int ERR_CNT_W      = 16;
  localparam int NUM_OF_SLAVES  = 2;
  localparam int NUM_OF_MASTERS = 2;

  // SLVERR and DECERR both carry bit 1 set.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/write_resp_channel_arbiter_if.sv
// B-channel bundle between the slave-side ports, master-side readies and the
// decoder selection outputs.
interface write_resp_arb_if #(
  parameter int Master_ID_Width = 1
);
  logic                       M00_AXI_bvalid;
  logic [1:0]                 M00_AXI_bresp;
  logic [Master_ID_Width-1:0] M00_AXI_bid;
  logic                       M00_AXI_bready;
  logic                       M01_AXI_bvalid;
  logic [1:0]                 M01_AXI_bresp;
  logic [Master_ID_Width-1:0] M01_AXI_bid;
  logic                       M01_AXI_bready;
  logic                       S00_AXI_bready;
  logic                       S01_AXI_bready;
  logic [Master_ID_Width-1:0] Sel_Resp_ID;
  logic                       Sel_Valid;
  logic [1:0]                 Sel_Write_Resp;

  // Handshake: a slave response transfers on a cycle where Mxx_AXI_bvalid and
  // Mxx_AXI_bready are both 1; the buffered response retires on a cycle where
  // Sel_Valid and the S0x_AXI_bready addressed by Sel_Resp_ID are both 1.
  // Sel_* hold steady while Sel_Valid is 1 and the response has not retired.

  // Arbiter side.
  modport slave (
    input  M00_AXI_bvalid, M00_AXI_bresp, M00_AXI_bid,
    input  M01_AXI_bvalid, M01_AXI_bresp, M01_AXI_bid,
    input  S00_AXI_bready, S01_AXI_bready,
    output M00_AXI_bready, M01_AXI_bready,
    output Sel_Resp_ID, Sel_Valid, Sel_Write_Resp
  );

  // Environment side (slaves, masters, decoder).
  modport master (
    output M00_AXI_bvalid, M00_AXI_bresp, M00_AXI_bid,
    output M01_AXI_bvalid, M01_AXI_bresp, M01_AXI_bid,
    output S00_AXI_bready, S01_AXI_bready,
    input  M00_AXI_bready, M01_AXI_bready,
    input  Sel_Resp_ID, Sel_Valid, Sel_Write_Resp
  );
endinterface

// File: rtl/write_resp_channel_arbiter_rr_arbiter_2.sv
// Two-way round-robin arbiter: the requester after last_grant has priority.
module rr_arbiter_2 (
  input  logic [1:0] request_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    if (last_grant_i) begin
      grant_o[0] = request_i[0];
      grant_o[1] = request_i[1] & ~request_i[0];
    end else begin
      grant_o[1] = request_i[1];
      grant_o[0] = request_i[0] & ~request_i[1];
    end
  end

endmodule

// File: rtl/write_resp_channel_arbiter.sv
// Round-robin B-response arbiter with a one-entry buffer feeding the decoder.
// Define WRITE_RESP_ARB_ERR_COUNT_EN to add the saturating Err_Count output.
module write_resp_channel_arbiter
  import write_resp_arb_pkg::*;
#(
  parameter int Master_ID_Width = 1
) (
  input  logic           ACLK,
  input  logic           ARESET,
  write_resp_arb_if.slave bus,
  output state_t         dbg_state_o
`ifdef WRITE_RESP_ARB_ERR_COUNT_EN
  ,
  output logic [ERR_CNT_W-1:0] Err_Count
`endif
);

  state_t                     state_q, state_d;
  logic [Master_ID_Width-1:0] sel_id_q, sel_id_d;
  logic [1:0]                 sel_resp_q, sel_resp_d;
  logic                       last_grant_q, last_grant_d;

  logic [NUM_OF_SLAVES-1:0]  req;
  logic [NUM_OF_SLAVES-1:0]  grant;
  logic [NUM_OF_MASTERS-1:0] m_ready;
  logic                      retire;
  logic                      capture;

  assign req     = {bus.M01_AXI_bvalid, bus.M00_AXI_bvalid};
  assign m_ready = {bus.S01_AXI_bready, bus.S00_AXI_bready};

  rr_arbiter_2 u_rr (
    .request_i    (req),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  always_comb begin
    state_d      = state_q;
    sel_id_d     = sel_id_q;
    sel_resp_d   = sel_resp_q;
    last_grant_d = last_grant_q;
    retire       = (state_q == ST_BUSY) && m_ready[sel_id_q];
    // The buffer can take a new response when empty or draining this cycle.
    capture      = ((state_q == ST_IDLE) || retire) && (|req);

    case (state_q)
      ST_IDLE: if (capture) state_d = ST_BUSY;
      ST_BUSY: if (retire && !capture) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (capture) begin
      last_grant_d = grant[1];
      sel_id_d     = grant[1] ? bus.M01_AXI_bid   : bus.M00_AXI_bid;
      sel_resp_d   = grant[1] ? bus.M01_AXI_bresp : bus.M00_AXI_bresp;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q      <= ST_IDLE;
      sel_id_q     <= '0;
      sel_resp_q   <= RESP_OKAY;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      sel_id_q     <= sel_id_d;
      sel_resp_q   <= sel_resp_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Reset gates bready so no slave handshake completes while it is asserted.
  assign bus.M00_AXI_bready = capture & grant[0] & ~ARESET;
  assign bus.M01_AXI_bready = capture & grant[1] & ~ARESET;
  assign bus.Sel_Valid      = (state_q == ST_BUSY);
  assign bus.Sel_Resp_ID    = sel_id_q;
  assign bus.Sel_Write_Resp = sel_resp_q;
  assign dbg_state_o        = state_q;

`ifdef WRITE_RESP_ARB_ERR_COUNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      err_cnt_q <= '0;
    end else if (retire && resp_is_err(sel_resp_q) && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign Err_Count = err_cnt_q;
`endif

endmodule
